// File: rtl/branch_comp_pkg.sv
// rtl/branch_comp_pkg.sv - shared types and helpers for the iterative branch comparator
package branch_comp_pkg;

  typedef enum logic [2:0] {
    FUNC_BEQ  = 3'b000,
    FUNC_BNE  = 3'b001,
    FUNC_BLT  = 3'b100,
    FUNC_BGE  = 3'b101,
    FUNC_BLTU = 3'b110,
    FUNC_BGEU = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // funct3 values 010/011 are not branch encodings
  function automatic logic is_illegal_func(input logic [2:0] f);
    return (f[2:1] == 2'b01);
  endfunction

  // Branch-taken decision from the final equal/less-than flags
  function automatic logic branch_taken(input logic [2:0] f, input logic eq, input logic lt);
    logic r;
    r = 1'b0;
    case (f)
      FUNC_BEQ:            r = eq;
      FUNC_BNE:            r = !eq;
      FUNC_BLT, FUNC_BLTU: r = lt;
      FUNC_BGE, FUNC_BGEU: r = !lt;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nbit_iter_branch_comp_if.sv
// rtl/nbit_iter_branch_comp_if.sv - request/result bundle of the iterative branch comparator
interface nbit_iter_branch_comp_if #(parameter int BITS = 32);

  logic            Start;
  logic [2:0]      Func;
  logic [BITS-1:0] Data0;
  logic [BITS-1:0] Data1;
  logic            Busy;
  logic            Done;
  logic            Out;
  logic            Eq;
  logic            Lt;
  logic            IllegalFunc;

  modport master (
    output Start, Func, Data0, Data1,
    input  Busy, Done, Out, Eq, Lt, IllegalFunc
  );

  modport slave (
    input  Start, Func, Data0, Data1,
    output Busy, Done, Out, Eq, Lt, IllegalFunc
  );

endinterface

// File: rtl/nbit_chunk_comp.sv
// rtl/nbit_chunk_comp.sv - combinational equal/less-than compare of one operand chunk
module nbit_chunk_comp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             signed_msb,
  output logic             eq,
  output logic             lt
);

  logic [CHUNK-1:0] msb_mask;

  // Flipping the sign bit turns a two's-complement compare into an unsigned one
  always_comb begin
    msb_mask            = '0;
    msb_mask[CHUNK-1]   = signed_msb;
  end

  assign eq = (a == b);
  assign lt = ((a ^ msb_mask) < (b ^ msb_mask));

endmodule

// File: rtl/nbit_iter_branch_comp.sv
// rtl/nbit_iter_branch_comp.sv - multi-cycle RISC-V branch comparator, MSB chunk first (NBIT_ITER_COMP_EARLY_EXIT_EN enables early exit)
module nbit_iter_branch_comp
  import branch_comp_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int CHUNK = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  nbit_iter_branch_comp_if.slave bus
);

  localparam int NCHUNK = BITS / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (BITS % CHUNK) != 0) begin : g_bad_chunk
      $error("nbit_iter_branch_comp: BITS must be a multiple of CHUNK");
    end
  endgenerate

  state_e          state, state_nxt;
  logic [IDXW-1:0] idx;
  logic [BITS-1:0] a_q, b_q;
  logic [2:0]      func_q;
  logic            out_q, eq_q, lt_q, ill_q;

  logic [CHUNK-1:0] ca, cb;
  logic             signed_msb, c_eq, c_lt;
  logic             fin, fin_eq, fin_lt;

  assign ca         = a_q[int'(idx) * CHUNK +: CHUNK];
  assign cb         = b_q[int'(idx) * CHUNK +: CHUNK];
  assign signed_msb = !func_q[1] && (idx == LAST);

  nbit_chunk_comp #(.CHUNK(CHUNK)) u_chunk (
    .a          (ca),
    .b          (cb),
    .signed_msb (signed_msb),
    .eq         (c_eq),
    .lt         (c_lt)
  );

`ifdef NBIT_ITER_COMP_EARLY_EXIT_EN
  // Stop at the first differing chunk; lower chunks cannot change the ordering
  assign fin    = !c_eq || (idx == '0);
  assign fin_eq = c_eq;
  assign fin_lt = !c_eq && c_lt;
`else
  logic decided, dlt;
  // Always scan every chunk; the first difference seen is sticky
  assign fin    = (idx == '0);
  assign fin_eq = !decided && c_eq;
  assign fin_lt = decided ? dlt : (!c_eq && c_lt);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept Start from IDLE or DONE, leave RUN when the scan is finished
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = bus.Start ? S_RUN : S_IDLE;
      S_RUN:          if (fin) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, chunk index and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      func_q <= '0;
      out_q  <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      ill_q  <= 1'b0;
`ifndef NBIT_ITER_COMP_EARLY_EXIT_EN
      decided <= 1'b0;
      dlt     <= 1'b0;
`endif
    end else if (state != S_RUN && bus.Start) begin
      a_q    <= bus.Data0;
      b_q    <= bus.Data1;
      func_q <= bus.Func;
      idx    <= LAST;
`ifndef NBIT_ITER_COMP_EARLY_EXIT_EN
      decided <= 1'b0;
      dlt     <= 1'b0;
`endif
    end else if (state == S_RUN) begin
      if (fin) begin
        eq_q  <= fin_eq;
        lt_q  <= fin_lt;
        out_q <= branch_taken(func_q, fin_eq, fin_lt);
        ill_q <= is_illegal_func(func_q);
      end else begin
        idx <= idx - IDXW'(1);
      end
`ifndef NBIT_ITER_COMP_EARLY_EXIT_EN
      if (!decided && !c_eq) begin
        decided <= 1'b1;
        dlt     <= c_lt;
      end
`endif
    end
  end

  assign bus.Busy        = (state == S_RUN);
  assign bus.Done        = (state == S_DONE);
  assign bus.Out         = out_q;
  assign bus.Eq          = eq_q;
  assign bus.Lt          = lt_q;
  assign bus.IllegalFunc = ill_q;

endmodule

// File: tb/tb_nbit_iter_branch_comp.sv
// tb/tb_nbit_iter_branch_comp.sv - self-checking bench for nbit_iter_branch_comp
module tb_nbit_iter_branch_comp;
  import branch_comp_pkg::*;

  localparam int BITS   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = BITS / CHUNK;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nbit_iter_branch_comp_if #(.BITS(BITS)) bus ();

  nbit_iter_branch_comp #(.BITS(BITS), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]      f;
    logic [BITS-1:0] d0;
    logic [BITS-1:0] d1;
    bit              o, e, l, il;
    int              lat_ee;
    int              lat_full;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: results straight from the branch definitions, latency from the top differing chunk
  function automatic vec_t model(input logic [2:0] f, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    vec_t v;
    int   top;
    v.f  = f; v.d0 = a; v.d1 = b;
    v.e  = (a == b);
    v.l  = f[1] ? (a < b) : ($signed(a) < $signed(b));
    v.il = (f == 3'b010) || (f == 3'b011);
    case (f)
      3'b000:         v.o = v.e;
      3'b001:         v.o = !v.e;
      3'b100, 3'b110: v.o = v.l;
      3'b101, 3'b111: v.o = !v.l;
      default:        v.o = 1'b0;
    endcase
    top = -1;
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (top < 0 && ((a >> (i * CHUNK)) != (b >> (i * CHUNK)))) top = i;
    end
    v.lat_ee   = (top < 0) ? NCHUNK + 1 : NCHUNK - top + 1;
    v.lat_full = NCHUNK + 1;
    return v;
  endfunction

  function automatic int pick_lat(input vec_t v);
`ifdef NBIT_ITER_COMP_EARLY_EXIT_EN
    return v.lat_ee;
`else
    return v.lat_full;
`endif
  endfunction

  // Call between clock edges; returns #1 after the accept edge with operands scrambled
  task automatic launch(input logic [2:0] f, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    bus.Start = 1'b1;
    bus.Func  = f;
    bus.Data0 = a;
    bus.Data1 = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.Func  = 3'($urandom);
    bus.Data0 = $urandom;
    bus.Data1 = $urandom;
  endtask

  // Counts clock edges (from the accept edge) until Done is seen at a negedge
  task automatic wait_done(input string tag, input int start_edges, output int edges);
    edges = start_edges;
    forever begin
      @(negedge clk);
      if (bus.Done === 1'b1) return;
      check({tag, "/busy"}, bus.Busy, 1);
      if (edges > NCHUNK + 3) begin
        edges = -1;
        return;
      end
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int edges);
    check({tag, "/lat"}, edges, pick_lat(v));
    check({tag, "/out"}, bus.Out, v.o);
    check({tag, "/eq"},  bus.Eq,  v.e);
    check({tag, "/lt"},  bus.Lt,  v.l);
    check({tag, "/ill"}, bus.IllegalFunc, v.il);
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int edges;
    launch(v.f, v.d0, v.d1);
    wait_done(tag, 1, edges);
    check_result(tag, v, edges);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "/pulse"}, bus.Done, 0);
    check({tag, "/hold"},  bus.Out,  v.o);
  endtask

  initial begin
    int   edges;
    int   ndone;
    vec_t v;
    logic [BITS-1:0] a, b;

    //          f       d0            d1            o  e  l  il ee full
    tbl[0] = '{3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0, 0, 5, 5};
    tbl[1] = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 1, 0, 1, 0, 2, 5};
    tbl[2] = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 2, 5};
    tbl[3] = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 1, 0, 0, 0, 2, 5};
    tbl[4] = '{3'b001, 32'h12345678, 32'h12345679, 1, 0, 1, 0, 5, 5};
    tbl[5] = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 0, 0, 1, 0, 2, 5};
    tbl[6] = '{3'b110, 32'h00000100, 32'h000000FF, 0, 0, 0, 0, 4, 5};
    tbl[7] = '{3'b000, 32'hAA000000, 32'hAB000000, 0, 0, 1, 0, 2, 5};
    tbl[8] = '{3'b011, 32'h00000005, 32'h00000003, 0, 0, 0, 1, 5, 5};

    bus.Start = 1'b0;
    bus.Func  = 3'b000;
    bus.Data0 = '0;
    bus.Data1 = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst/busy", bus.Busy, 0);
    check("rst/done", bus.Done, 0);
    check("rst/out",  bus.Out,  0);
    check("rst/eq",   bus.Eq,   0);
    check("rst/lt",   bus.Lt,   0);
    check("rst/ill",  bus.IllegalFunc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_and_check($sformatf("vec%0d", i), tbl[i]);
    end

    // Illegal funct3 with a second Start while Busy: exactly one Done
    v = '{3'b010, 32'hCAFE0000, 32'hCAFE0000, 0, 1, 0, 1, 5, 5};
    launch(v.f, v.d0, v.d1);
    bus.Start = 1'b1;
    bus.Func  = 3'b000;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    wait_done("ill", 2, edges);
    check_result("ill", v, edges);
    ndone = 0;
    for (int i = 0; i < NCHUNK + 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (bus.Done === 1'b1) ndone++;
    end
    check("ill/extra_done", ndone, 0);

    // Back-to-back: Start held during DONE launches the next operation
    v = model(3'b000, 32'h01020304, 32'h01020304);
    launch(v.f, v.d0, v.d1);
    wait_done("b2b_a", 1, edges);
    check_result("b2b_a", v, edges);
    v = model(3'b001, 32'h11000000, 32'h22000000);
    launch(v.f, v.d0, v.d1);
    wait_done("b2b_b", 1, edges);
    check_result("b2b_b", v, edges);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN aborts without Done
    run_and_check("pre_rst", model(3'b000, 32'h55555555, 32'h55555555));
    launch(3'b101, 32'h0F0F0F0F, 32'h0F0F0F0F);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort/busy", bus.Busy, 0);
    check("abort/done", bus.Done, 0);
    check("abort/out",  bus.Out,  0);
    check("abort/eq",   bus.Eq,   0);
    check("abort/lt",   bus.Lt,   0);
    check("abort/ill",  bus.IllegalFunc, 0);
    @(posedge clk);
    #1;
    run_and_check("post_rst", model(3'b101, 32'h00000005, 32'h00000003));

    // Randomised operations against the reference model
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = a;
        2:       b = a ^ (BITS'(1) << $urandom_range(0, BITS - 1));
        default: b = a ^ (BITS'($urandom) >> $urandom_range(1, BITS - 1));
      endcase
      run_and_check($sformatf("rnd%0d", i), model(3'($urandom), a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/nbit_iter_branch_comp.md
Name: nbit_iter_branch_comp

Overview:
- Multi-cycle, parametrised successor to the single-cycle N-bit equality comparator.
- Evaluates all six RISC-V branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) on two BITS-wide operands, CHUNK bits per cycle, scanning from the MSB chunk downward.
- Sits beside the branch unit when a multi-cycle datapath variant trades comparator area for latency.
- Start/Busy/Done handshake; result held until the next accepted Start.

Parameters:
- BITS, 32, operand width.
- CHUNK, 8, bits compared per cycle. BITS % CHUNK == 0 is required; elaboration error otherwise.
- NCHUNK, BITS/CHUNK, derived, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- Start  in  1  request; sampled on a clk edge while Busy==0.
- Func  in  3  funct3 encoding: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- Data0  in  BITS  operand rs1.
- Data1  in  BITS  operand rs2.
- Busy  out  1  high while scanning chunks.
- Done  out  1  one-cycle pulse when the result is valid.
- Out  out  1  branch-taken result.
- Eq  out  1  Data0 == Data1.
- Lt  out  1  Data0 < Data1, signed or unsigned per Func[1].
- IllegalFunc  out  1  Func was 010 or 011 at accept.

Behaviour:
- The clock is clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n==0 at an edge):
  - State goes to IDLE.
  - Busy, Done, Out, Eq, Lt and IllegalFunc all go to 0.
  - Asserting reset mid-RUN aborts the operation; no Done is issued.
- States:
  - IDLE: Start==1 latches Data0, Data1 and Func; sets idx=NCHUNK-1; goes to RUN.
  - RUN: compares chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK).
    - Chunks differ: set Eq=0. Set Lt from the chunk compare. Go to DONE (early exit).
    - Chunks equal and idx==0: set Eq=1, Lt=0. Go to DONE.
    - Otherwise idx decrements; stay in RUN.
  - DONE: Done=1 for exactly this cycle. Accepts Start as IDLE does (back-to-back operations). Returns to IDLE if Start==0.
- Signed compare: only chunk NCHUNK-1 treats its top bit as a sign bit, i.e. that bit is inverted before the unsigned chunk compare. Lower chunks are always unsigned.
- Out is Eq for BEQ, !Eq for BNE, Lt for BLT/BLTU, !Lt for BGE/BGEU.
- Illegal Func: the scan still runs; Out=0 and IllegalFunc=1; Eq and Lt remain valid.
- Latency:
  - Start high in cycle k; m = number of chunks examined (1..NCHUNK).
  - Done is high in cycle k+m+1.
  - Worst case is NCHUNK+1 cycles.
- Busy = (state==RUN). Start while Busy is ignored and is not queued.
- Out, Eq, Lt and IllegalFunc update only on the RUN->DONE transition and hold through IDLE.
- Operand changes after accept have no effect, because the latched copies are used.
- CHUNK==BITS is legal: always one RUN cycle.

Optional Feature:
- Macro: NBIT_ITER_COMP_EARLY_EXIT_EN.
- Defined: early exit on the first differing chunk, as described above. Latency is 2..NCHUNK+1 cycles.
- Undefined: all NCHUNK chunks are always scanned.
  - The first differing chunk (from MSB) is recorded in a sticky "decided" flag; later chunks cannot change Lt.
  - Latency is a constant NCHUNK+1 cycles, giving data-independent timing.
  - Results are identical to the defined case.

Decomposition:
- Package branch_comp_pkg:
  - Func enum (FUNC_BEQ..FUNC_BGEU).
  - State enum (S_IDLE, S_RUN, S_DONE).
  - Function is_illegal_func().
- One sub-module nbit_chunk_comp #(CHUNK): combinational chunk compare.
  - Inputs: a, b, signed_msb.
  - Outputs: eq, lt.
  - Instantiated once and muxed by idx.

Test Plan (BITS=32, CHUNK=8):
- BEQ, Data0=Data1=0xDEADBEEF, Start in cycle 0 -> Done in cycle 5; Out=1, Eq=1, Lt=0.
- BLT, Data0=0xFFFFFFFF (-1), Data1=0x00000001 -> Out=1, Lt=1. Early exit: Done in cycle 2. Without the macro: Done in cycle 5.
- BLTU with the same operands -> Out=0, Lt=0. BGEU -> Out=1.
- BNE, Data0=0x12345678, Data1=0x12345679 (differ only in the LSB chunk) -> Done in cycle 5; Out=1, Eq=0, Lt=1.
- Func=010 -> Out=0, IllegalFunc=1. A second Start issued while Busy is ignored: exactly one Done.
- Start BGE; drive rst_n=0 in cycle 2 -> no Done; all outputs 0 from cycle 3. A new Start in cycle 4 completes normally.
